// File: rtl/output_writeback.sv
// Final pipeline stage: buffers activation rows in a small FIFO and commits them to BRAM A.
// Optional macro WB_BYTE_MASK_EN: bram_we follows the validity_mask latched at start_writeback.
module output_writeback #(
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned MAT_MUL_SIZE = 4,
  parameter int unsigned AWIDTH       = 10,
  parameter int unsigned MASK_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_writeback,
  input  logic [AWIDTH-1:0]              address_mat_c,
  input  logic [7:0]                     num_rows,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  input  logic                           bram_read_req,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic [MASK_WIDTH-1:0]          bram_we,
  output logic                           bram_wr_active,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow_err,
  output logic                           done_writeback
);
  localparam int unsigned ROW_W = MAT_MUL_SIZE * DWIDTH;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  state_e                state_q, state_d;
  logic [ROW_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ROW_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [AWIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [7:0]            num_rows_q, num_rows_d, rows_written_q, rows_written_d;
  logic                  overflow_q, overflow_d, done_q, done_d;
  logic [AWIDTH-1:0]     addr_out_q, addr_out_d;
  logic [ROW_W-1:0]      wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] we_q, we_d, commit_we_c;
  logic                  wr_active_q, wr_active_d;
  logic                  full_c, pop_c, push_c;

`ifdef WB_BYTE_MASK_EN
  logic [MASK_WIDTH-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (state_q == IDLE && start_writeback) mask_d = validity_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_q <= '0;
    else       mask_q <= mask_d;
  end

  assign commit_we_c = mask_q;
`else
  logic unused_mask_c;
  assign unused_mask_c = ^validity_mask;
  assign commit_we_c   = {MASK_WIDTH{1'b1}};
`endif

  // Pop only while rows remain in the job; a pop frees a slot for a same-cycle push.
  assign full_c = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop_c  = (state_q == ACTIVE) && (level_q != '0) && !bram_read_req &&
                  (rows_written_q != num_rows_q);
  assign push_c = (state_q == ACTIVE) && in_data_available && (!full_c || pop_c);

  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    wr_addr_d      = wr_addr_q;
    num_rows_d     = num_rows_q;
    rows_written_d = rows_written_q;
    overflow_d     = overflow_q;
    addr_out_d     = '0;
    wdata_d        = '0;
    we_d           = '0;
    wr_active_d    = 1'b0;
    level_d        = LVL_W'(level_q + LVL_W'(push_c) - LVL_W'(pop_c));

    if (pop_c) begin
      addr_out_d     = wr_addr_q;
      wdata_d        = mem_q[rd_ptr_q];
      we_d           = commit_we_c;
      wr_active_d    = 1'b1;
      wr_addr_d      = AWIDTH'(wr_addr_q + AWIDTH'(MAT_MUL_SIZE));
      rows_written_d = 8'(rows_written_q + 8'd1);
      rd_ptr_d       = PTR_W'(rd_ptr_q + 1'b1);
    end

    if (push_c) begin
      mem_d[wr_ptr_q] = inp_data;
      wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
    end

    if (state_q == ACTIVE && in_data_available && !push_c) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_writeback) begin
          num_rows_d     = num_rows;
          wr_addr_d      = address_mat_c;
          rows_written_d = '0;
          state_d        = (num_rows == 8'd0) ? DONE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (rows_written_q == num_rows_q) state_d = DONE;
      end
      DONE: begin
        // Leftover rows from this job are flushed on the way back to IDLE.
        state_d  = IDLE;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        level_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_q          <= '{default: '0};
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      level_q        <= '0;
      wr_addr_q      <= '0;
      num_rows_q     <= '0;
      rows_written_q <= '0;
      overflow_q     <= 1'b0;
      done_q         <= 1'b0;
      addr_out_q     <= '0;
      wdata_q        <= '0;
      we_q           <= '0;
      wr_active_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      level_q        <= level_d;
      wr_addr_q      <= wr_addr_d;
      num_rows_q     <= num_rows_d;
      rows_written_q <= rows_written_d;
      overflow_q     <= overflow_d;
      done_q         <= done_d;
      addr_out_q     <= addr_out_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      wr_active_q    <= wr_active_d;
    end
  end

  assign bram_addr      = addr_out_q;
  assign bram_wdata     = wdata_q;
  assign bram_we        = we_q;
  assign bram_wr_active = wr_active_q;
  assign fifo_level     = level_q;
  assign overflow_err   = overflow_q;
  assign done_writeback = done_q;

endmodule

// File: tb/tb_output_writeback.sv
// Scoreboard bench for output_writeback: expected writes queued at row injection, popped by a write monitor.
`timescale 1ns/1ps
module tb_output_writeback;
  localparam int unsigned AW = 10;
  localparam int unsigned RW = 32;
  localparam int unsigned MW = 4;
`ifdef WB_BYTE_MASK_EN
  localparam bit MASK_BUILD = 1'b1;
`else
  localparam bit MASK_BUILD = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    logic [MW-1:0] we;
    int            cyc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          start_writeback;
  logic [AW-1:0] address_mat_c;
  logic [7:0]    num_rows;
  logic [MW-1:0] validity_mask;
  logic          in_data_available;
  logic [RW-1:0] inp_data;
  logic          bram_read_req;
  logic [AW-1:0] bram_addr;
  logic [RW-1:0] bram_wdata;
  logic [MW-1:0] bram_we;
  logic          bram_wr_active;
  logic [2:0]    fifo_level;
  logic          overflow_err;
  logic          done_writeback;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   wr_cnt   = 0;
  exp_t sb[$];
  exp_t mon_e;

  output_writeback dut (
    .clk              (clk),
    .reset            (reset),
    .start_writeback  (start_writeback),
    .address_mat_c    (address_mat_c),
    .num_rows         (num_rows),
    .validity_mask    (validity_mask),
    .in_data_available(in_data_available),
    .inp_data         (inp_data),
    .bram_read_req    (bram_read_req),
    .bram_addr        (bram_addr),
    .bram_wdata       (bram_wdata),
    .bram_we          (bram_we),
    .bram_wr_active   (bram_wr_active),
    .fifo_level       (fifo_level),
    .overflow_err     (overflow_err),
    .done_writeback   (done_writeback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every committed write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (done_writeback) done_cnt++;
      if (bram_wr_active) begin
        wr_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h we=%h, required no write",
                   bram_addr, bram_wdata, bram_we);
        end else begin
          mon_e = sb.pop_front();
          if (bram_addr !== mon_e.addr || bram_wdata !== mon_e.data || bram_we !== mon_e.we ||
              (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h we=%h cyc=%0d, required addr=%h data=%h we=%h cyc=%0d",
                     bram_addr, bram_wdata, bram_we, cyc, mon_e.addr, mon_e.data, mon_e.we, mon_e.cyc);
          end
        end
      end else begin
        checks++;
        if (bram_we !== '0 || bram_wdata !== '0) begin
          errors++;
          $display("FAIL idle_outputs: got we=%h wdata=%h, required 0", bram_we, bram_wdata);
        end
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] a, input logic [7:0] n, input logic [MW-1:0] m);
    start_writeback = 1'b1;
    address_mat_c   = a;
    num_rows        = n;
    validity_mask   = m;
    @(negedge clk);
    start_writeback = 1'b0;
  endtask

  task automatic drive_row(input logic [RW-1:0] d, input logic [AW-1:0] a, input logic [MW-1:0] we,
                           input bit expect_wr, input bit timed);
    exp_t e;
    in_data_available = 1'b1;
    inp_data          = d;
    if (expect_wr) begin
      e.addr = a;
      e.data = d;
      e.we   = we;
      e.cyc  = timed ? cyc + 2 : -1;
      sb.push_back(e);
    end
    @(negedge clk);
    in_data_available = 1'b0;
    inp_data          = '0;
  endtask

  task automatic wait_drain(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bram_addr, bram_wdata, bram_we, bram_wr_active, fifo_level, overflow_err, done_writeback} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h we=%h act=%b lvl=%0d ovf=%b done=%b, required all 0",
               bram_addr, bram_wdata, bram_we, bram_wr_active, fifo_level, overflow_err, done_writeback);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || done_writeback !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got lvl=%0d done=%b, required 0 0", fifo_level, done_writeback);
    end
  endtask

  task automatic test_basic();
    logic [7:0] b;
    bit ok;
    done_cnt = 0;
    start_job(10'h040, 8'd4, 4'hF);
    for (int i = 0; i < 4; i++) begin
      b = 8'(17 * (i + 1));
      drive_row({b, b, b, b}, AW'(10'h040 + 4 * i), 4'hF, 1'b1, 1'b1);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_drain: got %0d pending, required 0", sb.size()); end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt); end
    checks++;
    if (overflow_err !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL basic_state: got ovf=%b lvl=%0d, required 0 0", overflow_err, fifo_level);
    end
  endtask

  task automatic test_stall();
    bit ok;
    done_cnt      = 0;
    start_job(10'h100, 8'd3, 4'hF);
    bram_read_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive_row(32'hA000_0000 + 32'(i), AW'(10'h100 + 4 * i), 4'hF, 1'b1, 1'b0);
      else       @(negedge clk);
      checks++;
      if (bram_wr_active !== 1'b0 || bram_we !== '0) begin
        errors++;
        $display("FAIL stall_no_write: got act=%b we=%h, required 0 0", bram_wr_active, bram_we);
      end
    end
    checks++;
    if (fifo_level !== 3'd3) begin errors++; $display("FAIL stall_level: got %0d, required 3", fifo_level); end
    bram_read_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bram_wr_active !== 1'b1) begin
        errors++;
        $display("FAIL stall_back_to_back: got act=%b at write %0d, required 1", bram_wr_active, k);
      end
    end
    wait_drain(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_drain: got %0d pending, required 0", sb.size()); end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != 1 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got done=%0d ovf=%b, required 1 0", done_cnt, overflow_err);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    done_cnt      = 0;
    start_job(10'h200, 8'd5, 4'hF);
    bram_read_req = 1'b1;
    for (int i = 0; i < 5; i++)
      drive_row(32'hB000_0000 + 32'(i), AW'(10'h200 + 4 * i), 4'hF, i < 4, 1'b0);
    checks++;
    if (fifo_level !== 3'd4 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got lvl=%0d ovf=%b, required 4 1", fifo_level, overflow_err);
    end
    bram_read_req = 1'b0;
    wait_drain(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_drain: got %0d pending, required 0", sb.size()); end
    repeat (8) @(negedge clk);
    checks++;
    if (done_cnt != 0 || fifo_level !== 3'd0 || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after: got done=%0d lvl=%0d ovf=%b, required 0 0 1", done_cnt, fifo_level, overflow_err);
    end
    do_reset();
    checks++;
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", overflow_err); end
  endtask

  task automatic test_wrap();
    bit ok;
    done_cnt = 0;
    start_job(10'h3FC, 8'd2, 4'hF);
    drive_row(32'hCAFE_0001, 10'h3FC, 4'hF, 1'b1, 1'b1);
    drive_row(32'hCAFE_0002, 10'h000, 4'hF, 1'b1, 1'b1);
    wait_drain(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_drain: got %0d pending, required 0", sb.size()); end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL wrap_done: got %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    done_cnt = 0;
    wr_cnt   = 0;
    start_job(10'h080, 8'd4, 4'hF);
    for (int i = 0; i < 3; i++)
      drive_row(32'hD000_0000 + 32'(i), AW'(10'h080 + 4 * i), 4'hF, 1'b1, 1'b1);
    in_data_available = 1'b1;
    inp_data          = 32'hD000_0003;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (wr_cnt != 2) begin errors++; $display("FAIL mid_write_count: got %0d, required 2", wr_cnt); end
    checks++;
    if ({bram_addr, bram_wdata, bram_we, bram_wr_active, fifo_level, done_writeback} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got addr=%h wdata=%h we=%h act=%b lvl=%0d done=%b, required all 0",
               bram_addr, bram_wdata, bram_we, bram_wr_active, fifo_level, done_writeback);
    end
    in_data_available = 1'b0;
    inp_data          = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_job(10'h0C0, 8'd1, 4'hF);
    drive_row(32'hC0C0_C0C0, 10'h0C0, 4'hF, 1'b1, 1'b1);
    wait_drain(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_restart_drain: got %0d pending, required 0", sb.size()); end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL mid_restart_done: got %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_mask_zero();
    bit ok;
    logic [MW-1:0] exp_we;
    exp_we   = MASK_BUILD ? 4'b0101 : 4'hF;
    done_cnt = 0;
    start_job(10'h010, 8'd1, 4'b0101);
    validity_mask = 4'hF;
    drive_row(32'h5A5A_5A5A, 10'h010, exp_we, 1'b1, 1'b1);
    wait_drain(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mask_drain: got %0d pending, required 0", sb.size()); end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL mask_done: got %0d pulses, required 1", done_cnt); end
    done_cnt = 0;
    start_job(10'h020, 8'd0, 4'hF);
    checks++;
    if (done_writeback !== 1'b1) begin errors++; $display("FAIL zero_done: got %b, required 1", done_writeback); end
    @(negedge clk);
    checks++;
    if (done_writeback !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b, required 0", done_writeback); end
    drive_row(32'hEEEE_EEEE, 10'h000, 4'hF, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != 1 || fifo_level !== 3'd0 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_row_ignored: got done=%0d lvl=%0d ovf=%b, required 1 0 0", done_cnt, fifo_level, overflow_err);
    end
  endtask

  initial begin
    reset             = 1'b1;
    start_writeback   = 1'b0;
    address_mat_c     = '0;
    num_rows          = '0;
    validity_mask     = '0;
    in_data_available = 1'b0;
    inp_data          = '0;
    bram_read_req     = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_mask_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
